motor_signal_gen: RTL and testbench
===================================

Name: motor_signal_gen

Overview:
Synthesises the signed 16-bit motor current/vibration sample stream that the RMS feature extractor consumes. It produces one sample per enable strobe, with a selectable fault signature (healthy, imbalance, bearing, broken rotor bar) and a DC offset. It marks 1024-sample frame boundaries so each fault mode stays constant across a full analysis window. It sits at the head of the simulation chain and drives the extractor's signal input.

Parameters:
FRAME_LEN, 1024, samples per analysis frame; sample index wraps at FRAME_LEN-1.
PHASE_W, 16, phase accumulator width.
IMPULSE_PERIOD, 100, samples between bearing-fault impulses.
NOISE_SHIFT, 4, arithmetic right shift applied to LFSR noise.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  one sample generated per cycle while high
freq_word  in  PHASE_W  phase increment per sample
fault_mode  in  2  0 healthy, 1 imbalance, 2 bearing, 3 broken bar
dc_offset  in  16 signed  added to every sample
signal  out  16 signed  generated sample
sample_valid  out  1  signal holds a new sample this cycle
frame_start  out  1  high with sample_valid on sample index 0

Behaviour:
- Reset (synchronous, active-high): phase=0, sample_idx=0, impulse_cnt=0, LFSR=0xACE1, latched mode=0, pipeline valids cleared; signal=0, sample_valid=0, frame_start=0.
- Two-stage pipeline: an enable-high cycle produces sample_valid exactly 2 cycles later. Stage registers advance every cycle; enable low inserts a bubble. There is no backpressure.
- Stage 1, on enable: phase += freq_word (wraps mod 2^PHASE_W); sample_idx += 1, wrapping FRAME_LEN-1 -> 0; LFSR steps once (Galois, taps x^16+x^14+x^13+x^11+1). When sample_idx==0, fault_mode is latched and the latched value applies to the whole frame. Mid-frame fault_mode changes are ignored.
- Sine: sine_lut, 65 entries, lut[k]=round(16000*sin(pi/2*k/64)). Quadrant q=phase[15:14], a=phase[13:8]. Values: q0 lut[a], q1 lut[64-a], q2 -lut[a], q3 -lut[64-a].
- base = sine(phase)>>>1.
- Mode 0: base.
- Mode 1: base + (sine(2*phase mod 2^16)>>>2).
- Mode 2: base + burst. burst = 8000>>>impulse_cnt while impulse_cnt<8, else 0. impulse_cnt counts samples 0..IMPULSE_PERIOD-1 and returns to 0 when a frame latches mode 2.
- Mode 3: base when sample_idx[6]==0, else sine>>>2.
- Stage 2: sum = mode term + dc_offset + noise, computed at 18 bits and saturated to [-32768, 32767]. Result is registered onto signal. frame_start=1 iff the sample's index is 0.
- signal holds its last value while sample_valid=0.
- rst mid-operation flushes the pipeline at once; the first post-reset sample is index 0 with frame_start=1.

Optional Feature:
NOISE_EN
- Defined: noise = $signed(lfsr)>>>NOISE_SHIFT.
- Undefined: noise = 0. The LFSR still steps, so sequences stay aligned when the macro is toggled.

Decomposition:
- Package motor_sim_pkg:
  - fault mode constants FAULT_HEALTHY/IMBALANCE/BEARING/BROKEN_BAR
  - SINE_PEAK=16000
  - LFSR_SEED=16'hACE1 and tap mask
  - BURST_AMP=8000, BURST_LEN=8
- Sub-module sine_lut: combinational, phase in, signed 16 out. Two instances (fundamental and 2nd harmonic).

Test Plan:
- rst, then enable=1, freq_word=0x4000, mode 0, offset 0, no NOISE_EN -> first sample_valid 2 cycles after enable with frame_start=1; signal 0, 8000, 0, -8000 repeating.
- freq_word=0x2000, mode 1 -> samples 0, 9657 (5657+4000), 8000, 1657, ...; sample 1 checked exactly.
- freq_word=0, mode 2 -> samples 0..7 = 8000, 4000, 2000, 1000, 500, 250, 125, 62; then 0 until sample 100 = 8000 again.
- Mode 0 running, fault_mode set to 3 at sample 500 -> output unchanged until sample 1024 (frame_start=1); samples 1088..1151 use >>>2 amplitude.
- dc_offset=0x7000, freq_word=0x4000 -> sample 1 saturates to 32767. dc_offset=0x8000 -> sample 3 saturates to -32768.
- rst asserted at sample 300 -> sample_valid=0 and signal=0 next cycle; after release, first sample is 0 with frame_start=1. With NOISE_EN defined and freq_word=0, the first sample is -1330.

Source files
------------

// File: rtl/motor_sim_pkg.sv
// -----------------------------------------------------------------------------
// motor_sim_pkg
// Shared constants and helpers for the motor signal generator:
//   - fault mode codes (healthy, imbalance, bearing, broken rotor bar)
//   - sine peak amplitude, LFSR seed and Galois tap mask
//   - bearing-fault burst amplitude and length
//   - lfsr_next : one Galois LFSR step
//   - sat16     : saturate an 18-bit signed sum to the 16-bit sample range
// -----------------------------------------------------------------------------
package motor_sim_pkg;

    localparam logic [1:0] FAULT_HEALTHY    = 2'd0;
    localparam logic [1:0] FAULT_IMBALANCE  = 2'd1;
    localparam logic [1:0] FAULT_BEARING    = 2'd2;
    localparam logic [1:0] FAULT_BROKEN_BAR = 2'd3;

    localparam int SINE_PEAK = 16000;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int BURST_AMP = 8000;
    localparam int BURST_LEN = 8;

    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        logic [15:0] shifted;
        shifted = {1'b0, state[15:1]};
        if (state[0]) begin
            return shifted ^ LFSR_TAPS;
        end else begin
            return shifted;
        end
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [17:0] value);
        if (value > 18'sd32767) begin
            return 16'sh7FFF;
        end else if (value < -18'sd32768) begin
            return 16'sh8000;
        end else begin
            return $signed(value[15:0]);
        end
    endfunction

endpackage

// File: rtl/motor_signal_gen_sine_lut.sv
// -----------------------------------------------------------------------------
// sine_lut
// Combinational quarter-wave sine table (65 entries, peak SINE_PEAK).
// Ports:
//   phase : in  [7:0]  top phase bits; [7:6] quadrant, [5:0] table position
//   sine  : out signed [15:0]  sine sample
// -----------------------------------------------------------------------------
module sine_lut
    import motor_sim_pkg::*;
(
    input  logic        [7:0]  phase,
    output logic signed [15:0] sine
);

    // round(16000 * sin(pi/2 * k/64)), k = 0..64
    function automatic logic [15:0] quarter_wave(input logic [6:0] k);
        case (k)
            7'd0:  return 16'd0;     7'd1:  return 16'd393;   7'd2:  return 16'd785;
            7'd3:  return 16'd1177;  7'd4:  return 16'd1568;  7'd5:  return 16'd1959;
            7'd6:  return 16'd2348;  7'd7:  return 16'd2735;  7'd8:  return 16'd3121;
            7'd9:  return 16'd3506;  7'd10: return 16'd3888;  7'd11: return 16'd4267;
            7'd12: return 16'd4645;  7'd13: return 16'd5019;  7'd14: return 16'd5390;
            7'd15: return 16'd5758;  7'd16: return 16'd6123;  7'd17: return 16'd6484;
            7'd18: return 16'd6841;  7'd19: return 16'd7194;  7'd20: return 16'd7542;
            7'd21: return 16'd7886;  7'd22: return 16'd8226;  7'd23: return 16'd8560;
            7'd24: return 16'd8889;  7'd25: return 16'd9213;  7'd26: return 16'd9531;
            7'd27: return 16'd9844;  7'd28: return 16'd10150; 7'd29: return 16'd10451;
            7'd30: return 16'd10745; 7'd31: return 16'd11033; 7'd32: return 16'd11314;
            7'd33: return 16'd11588; 7'd34: return 16'd11855; 7'd35: return 16'd12115;
            7'd36: return 16'd12368; 7'd37: return 16'd12614; 7'd38: return 16'd12851;
            7'd39: return 16'd13081; 7'd40: return 16'd13304; 7'd41: return 16'd13518;
            7'd42: return 16'd13724; 7'd43: return 16'd13921; 7'd44: return 16'd14111;
            7'd45: return 16'd14292; 7'd46: return 16'd14464; 7'd47: return 16'd14627;
            7'd48: return 16'd14782; 7'd49: return 16'd14928; 7'd50: return 16'd15065;
            7'd51: return 16'd15192; 7'd52: return 16'd15311; 7'd53: return 16'd15420;
            7'd54: return 16'd15521; 7'd55: return 16'd15611; 7'd56: return 16'd15693;
            7'd57: return 16'd15764; 7'd58: return 16'd15827; 7'd59: return 16'd15880;
            7'd60: return 16'd15923; 7'd61: return 16'd15957; 7'd62: return 16'd15981;
            7'd63: return 16'd15995; 7'd64: return 16'(SINE_PEAK);
            default: return 16'd0;
        endcase
    endfunction

    logic [6:0]  lut_idx_s;
    logic [15:0] mag_s;

    // Fold the phase into one quarter wave, then restore the sign for the lower half.
    always_comb begin
        lut_idx_s = 7'd0;
        mag_s     = 16'd0;
        sine      = 16'sd0;
        if (phase[6]) begin
            lut_idx_s = 7'd64 - {1'b0, phase[5:0]};
        end else begin
            lut_idx_s = {1'b0, phase[5:0]};
        end
        mag_s = quarter_wave(lut_idx_s);
        if (phase[7]) begin
            sine = -$signed(mag_s);
        end else begin
            sine = $signed(mag_s);
        end
    end

endmodule

// File: rtl/motor_signal_gen.sv
// -----------------------------------------------------------------------------
// motor_signal_gen
// Synthesises a signed 16-bit motor current/vibration sample stream with a
// selectable fault signature, DC offset and 1024-sample frame markers.
// Two-stage pipeline: an enable cycle yields sample_valid two cycles later.
// Optional feature macro NOISE_EN: when defined, LFSR noise (>>> NOISE_SHIFT)
// is added to every sample; otherwise noise is zero but the LFSR still steps.
// Ports:
//   clk          : in  system clock
//   rst          : in  synchronous active-high reset
//   enable       : in  generate one sample this cycle
//   freq_word    : in  [PHASE_W-1:0] phase increment per sample
//   fault_mode   : in  [1:0] 0 healthy, 1 imbalance, 2 bearing, 3 broken bar
//   dc_offset    : in  signed [15:0] added to every sample
//   signal       : out signed [15:0] generated sample (held when not valid)
//   sample_valid : out new sample on signal this cycle
//   frame_start  : out with sample_valid on sample index 0
// -----------------------------------------------------------------------------
module motor_signal_gen
    import motor_sim_pkg::*;
#(
    parameter int FRAME_LEN      = 1024,
    parameter int PHASE_W        = 16,
    parameter int IMPULSE_PERIOD = 100,
    parameter int NOISE_SHIFT    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic        [PHASE_W-1:0] freq_word,
    input  logic        [1:0]         fault_mode,
    input  logic signed [15:0]        dc_offset,
    output logic signed [15:0]        signal,
    output logic                      sample_valid,
    output logic                      frame_start
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam int IMP_W = $clog2(IMPULSE_PERIOD);

`ifdef NOISE_EN
    localparam bit NOISE_ON = 1'b1;
`else
    localparam bit NOISE_ON = 1'b0;
`endif

    // Generator state
    logic        [PHASE_W-1:0] phase_r;
    logic        [IDX_W-1:0]   idx_r;
    logic        [IMP_W-1:0]   imp_r;
    logic        [15:0]        lfsr_r;
    logic        [1:0]         mode_r;

    // Stage-1 pipeline registers
    logic                      s1_valid_r;
    logic                      s1_first_r;
    logic signed [15:0]        s1_term_r;
    logic signed [15:0]        s1_noise_r;
    logic signed [15:0]        s1_dc_r;

    // Stage-1 combinational values
    logic                      first_s;
    logic        [1:0]         mode_s;
    logic        [IMP_W-1:0]   imp_s;
    logic        [IDX_W-1:0]   idx_next_s;
    logic        [IMP_W-1:0]   imp_next_s;
    logic signed [15:0]        fund_s;
    logic signed [15:0]        harm_s;
    logic signed [15:0]        base_s;
    logic signed [15:0]        burst_s;
    logic signed [15:0]        term_s;
    logic signed [15:0]        noise_s;
    logic signed [17:0]        sum_s;

    // Fundamental and 2nd harmonic; the harmonic's phase is 2*phase mod 2^PHASE_W.
    sine_lut u_sine_fund (
        .phase (phase_r[PHASE_W-1 -: 8]),
        .sine  (fund_s)
    );

    sine_lut u_sine_harm (
        .phase (phase_r[PHASE_W-2 -: 8]),
        .sine  (harm_s)
    );

    // Stage 1: latch the mode at frame start and build the fault-mode term.
    always_comb begin
        first_s    = (idx_r == '0);
        mode_s     = mode_r;
        imp_s      = imp_r;
        idx_next_s = idx_r + IDX_W'(1);
        imp_next_s = '0;
        base_s     = fund_s >>> 1;
        burst_s    = 16'sd0;
        term_s     = 16'sd0;
        noise_s    = 16'sd0;

        if (first_s) begin
            mode_s = fault_mode;
        end else begin
            mode_s = mode_r;
        end

        // A frame that latches the bearing mode restarts the impulse train.
        if (first_s && (fault_mode == FAULT_BEARING)) begin
            imp_s = '0;
        end else begin
            imp_s = imp_r;
        end

        if (idx_r == IDX_W'(FRAME_LEN - 1)) begin
            idx_next_s = '0;
        end else begin
            idx_next_s = idx_r + IDX_W'(1);
        end

        if (imp_s == IMP_W'(IMPULSE_PERIOD - 1)) begin
            imp_next_s = '0;
        end else begin
            imp_next_s = imp_s + IMP_W'(1);
        end

        // Decaying burst: amplitude halves on each of the first BURST_LEN samples.
        if (imp_s < IMP_W'(BURST_LEN)) begin
            burst_s = 16'(BURST_AMP) >>> imp_s[2:0];
        end else begin
            burst_s = 16'sd0;
        end

        case (mode_s)
            FAULT_HEALTHY:   term_s = base_s;
            FAULT_IMBALANCE: term_s = base_s + (harm_s >>> 2);
            FAULT_BEARING:   term_s = base_s + burst_s;
            FAULT_BROKEN_BAR: begin
                if (idx_r[6]) begin
                    term_s = fund_s >>> 2;
                end else begin
                    term_s = base_s;
                end
            end
            default:         term_s = base_s;
        endcase

        if (NOISE_ON) begin
            noise_s = $signed(lfsr_r) >>> NOISE_SHIFT;
        end else begin
            noise_s = 16'sd0;
        end

        sum_s = 18'(s1_term_r) + 18'(s1_noise_r) + 18'(s1_dc_r);
    end

    // Stage 1 registers and generator state; enable low inserts a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r    <= '0;
            idx_r      <= '0;
            imp_r      <= '0;
            lfsr_r     <= LFSR_SEED;
            mode_r     <= FAULT_HEALTHY;
            s1_valid_r <= 1'b0;
            s1_first_r <= 1'b0;
            s1_term_r  <= 16'sd0;
            s1_noise_r <= 16'sd0;
            s1_dc_r    <= 16'sd0;
        end else begin
            s1_valid_r <= enable;
            if (enable) begin
                phase_r    <= phase_r + freq_word;
                idx_r      <= idx_next_s;
                imp_r      <= imp_next_s;
                lfsr_r     <= lfsr_next(lfsr_r);
                mode_r     <= mode_s;
                s1_first_r <= first_s;
                s1_term_r  <= term_s;
                s1_noise_r <= noise_s;
                // Offset travels with its sample so it is applied as seen at enable.
                s1_dc_r    <= dc_offset;
            end
        end
    end

    // Stage 2: saturating sum onto the registered outputs; signal holds between samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            signal       <= 16'sd0;
            sample_valid <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            sample_valid <= s1_valid_r;
            frame_start  <= s1_valid_r & s1_first_r;
            if (s1_valid_r) begin
                signal <= sat16(sum_s);
            end
        end
    end

endmodule

// File: tb/tb_motor_signal_gen.sv
// -----------------------------------------------------------------------------
// tb_motor_signal_gen
// Scoreboard bench: the driver pushes model samples (with the cycle they are
// due) as each enable is issued; an independent monitor pops and compares
// whenever the DUT presents sample_valid. Directed runs also spot-check
// individual samples against known constants.
// -----------------------------------------------------------------------------
module tb_motor_signal_gen;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               enable = 1'b0;
    logic        [15:0] freq_word = 16'd0;
    logic        [1:0]  fault_mode = 2'd0;
    logic signed [15:0] dc_offset = 16'sd0;
    logic signed [15:0] signal;
    logic               sample_valid;
    logic               frame_start;

    always #5 clk = ~clk;

    motor_signal_gen dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .freq_word    (freq_word),
        .fault_mode   (fault_mode),
        .dc_offset    (dc_offset),
        .signal       (signal),
        .sample_valid (sample_valid),
        .frame_start  (frame_start)
    );

    typedef struct {
        int sig;
        bit fs;
        int due;
    } exp_t;

    exp_t        sb[$];
    int          obs_sig[$];
    bit          obs_fs[$];
    int          lut_ref[65];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic signed [15:0] last_sig = 16'sd0;

    // reference model state
    int          m_phase, m_idx, m_imp, m_mode;
    logic [15:0] m_lfsr;

    always @(posedge clk) cyc = cyc + 1;

    function automatic int sine_ref(input int ph);
        int q, a;
        q = (ph >> 14) & 3;
        a = (ph >> 8) & 63;
        case (q)
            0: return lut_ref[a];
            1: return lut_ref[64 - a];
            2: return -lut_ref[a];
            default: return -lut_ref[64 - a];
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0; m_idx = 0; m_imp = 0; m_mode = 0;
        m_lfsr  = 16'hACE1;
    endtask

    task automatic model_push(input logic [15:0] fw, input logic [1:0] fm,
                              input logic [15:0] dc);
        exp_t e;
        int s, base, term, noise, sum;
        logic signed [15:0] tmp;
        bit first;
        first = (m_idx == 0);
        if (first) begin
            m_mode = int'(fm);
            if (fm == 2'd2) m_imp = 0;
        end
        s    = sine_ref(m_phase);
        base = s >>> 1;
        case (m_mode)
            1: term = base + (sine_ref((2 * m_phase) % 65536) >>> 2);
            2: term = base + ((m_imp < 8) ? (8000 >>> m_imp) : 0);
            3: term = ((m_idx & 64) != 0) ? (s >>> 2) : base;
            default: term = base;
        endcase
`ifdef NOISE_EN
        tmp = m_lfsr;
        noise = tmp;
        noise = noise >>> 4;
`else
        noise = 0;
`endif
        tmp = dc;
        sum = term + int'(tmp) + noise;
        if (sum > 32767) sum = 32767;
        if (sum < -32768) sum = -32768;
        e.sig = sum; e.fs = first; e.due = cyc + 2;
        sb.push_back(e);
        m_phase = (m_phase + int'(fw)) % 65536;
        m_idx   = (m_idx + 1) % 1024;
        m_imp   = (m_imp + 1) % 100;
        m_lfsr  = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    endtask

    task automatic drive(input bit en, input logic [15:0] fw, input logic [1:0] fm,
                         input logic [15:0] dc);
        @(negedge clk);
        rst = 1'b0; enable = en; freq_word = fw; fault_mode = fm; dc_offset = dc;
        if (en) model_push(fw, fm, dc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, freq_word, fault_mode, dc_offset);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1; enable = 1'b0;
        sb.delete(); obs_sig.delete(); obs_fs.delete();
        model_reset();
        for (int i = 1; i < n; i++) @(negedge clk);
    endtask

    task automatic spot(input string name, input int k, input int expv);
        vectors++;
        if (k >= obs_sig.size()) begin
            miscompares++;
            $display("FAIL %s: sample %0d never observed, expected %0d", name, k, expv);
        end else if (obs_sig[k] != expv) begin
            miscompares++;
            $display("FAIL %s: sample %0d got %0d expected %0d", name, k, obs_sig[k], expv);
        end
    endtask

    task automatic spot_fs(input string name, input int k, input bit expv);
        vectors++;
        if (k >= obs_fs.size()) begin
            miscompares++;
            $display("FAIL %s: sample %0d never observed, expected frame_start %0b", name, k, expv);
        end else if (obs_fs[k] != expv) begin
            miscompares++;
            $display("FAIL %s: sample %0d frame_start got %0b expected %0b", name, k, obs_fs[k], expv);
        end
    endtask

    // Monitor: compares every DUT sample with the scoreboard head and checks timing.
    always @(posedge clk) begin
        bit rst_edge;
        exp_t e;
        rst_edge = rst;
        #1;
        if (rst_edge) begin
            vectors++;
            if (sample_valid !== 1'b0 || signal !== 16'sd0 || frame_start !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state: valid=%b signal=%0d fs=%b, expected 0/0/0",
                         sample_valid, signal, frame_start);
            end
        end else if (sample_valid === 1'b1) begin
            vectors++;
            obs_sig.push_back(int'(signal));
            obs_fs.push_back(frame_start);
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_sample: signal=%0d at cycle %0d, expected none", signal, cyc);
            end else begin
                e = sb.pop_front();
                if (e.due != cyc || int'(signal) != e.sig || frame_start !== e.fs) begin
                    miscompares++;
                    $display("FAIL sample: got %0d fs=%b cycle %0d, expected %0d fs=%b cycle %0d",
                             signal, frame_start, cyc, e.sig, e.fs, e.due);
                end
            end
        end else begin
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                vectors++;
                miscompares++;
                e = sb.pop_front();
                $display("FAIL missing_sample: no valid at cycle %0d, expected %0d", cyc, e.sig);
            end
            vectors++;
            if (signal !== last_sig) begin
                miscompares++;
                $display("FAIL hold: signal %0d changed without valid, expected %0d", signal, last_sig);
            end
        end
        last_sig = signal;
    end

    initial begin
        int burst_exp[8];
        logic [15:0] dcv;
        burst_exp = '{8000, 4000, 2000, 1000, 500, 250, 125, 62};
        for (int k = 0; k <= 64; k++)
            lut_ref[k] = int'($floor(16000.0 * $sin(3.141592653589793 * k / 128.0) + 0.5));
        model_reset();

        // Healthy quarter-rate sine
        do_reset(3);
        for (int i = 0; i < 8; i++) drive(1'b1, 16'h4000, 2'd0, 16'h0000);
        idle(4);
`ifndef NOISE_EN
        spot("healthy_s0", 0, 0);
        spot("healthy_s1", 1, 8000);
        spot("healthy_s3", 3, -8000);
        spot_fs("healthy_fs0", 0, 1'b1);
        spot_fs("healthy_fs1", 1, 1'b0);
`endif

        // Imbalance
        do_reset(2);
        for (int i = 0; i < 4; i++) drive(1'b1, 16'h2000, 2'd1, 16'h0000);
        idle(4);
`ifndef NOISE_EN
        spot("imbalance_s1", 1, 9657);
        spot("imbalance_s3", 3, 1657);
`endif

        // Bearing bursts
        do_reset(2);
        for (int i = 0; i < 110; i++) drive(1'b1, 16'h0000, 2'd2, 16'h0000);
        idle(4);
`ifndef NOISE_EN
        for (int k = 0; k < 8; k++) spot("bearing_burst", k, burst_exp[k]);
        spot("bearing_gap", 8, 0);
        spot("bearing_gap99", 99, 0);
        spot("bearing_s100", 100, 8000);
`endif

        // Broken bar requested mid-frame only takes effect on the next frame
        do_reset(2);
        for (int i = 0; i < 1160; i++)
            drive(1'b1, 16'h4000, (i < 500) ? 2'd0 : 2'd3, 16'h0000);
        idle(4);
        spot_fs("frame_fs1024", 1024, 1'b1);
`ifndef NOISE_EN
        spot("bar_ignored_s501", 501, 8000);
        spot("bar_s1025", 1025, 8000);
        spot("bar_s1089", 1089, 4000);
        spot("bar_s1091", 1091, -4000);
        spot("bar_s1153", 1153, 8000);
`endif

        // Saturation
        do_reset(2);
        for (int i = 0; i < 4; i++) drive(1'b1, 16'h4000, 2'd0, 16'h7000);
        idle(4);
        spot("sat_high", 1, 32767);
        do_reset(2);
        for (int i = 0; i < 4; i++) drive(1'b1, 16'h4000, 2'd0, 16'h8000);
        idle(4);
        spot("sat_low", 3, -32768);

        // Reset mid-run flushes the pipeline
        do_reset(2);
        for (int i = 0; i < 300; i++) drive(1'b1, 16'h4000, 2'd0, 16'h0000);
        do_reset(2);
        for (int i = 0; i < 4; i++) drive(1'b1, 16'h0000, 2'd0, 16'h0000);
        idle(4);
        spot_fs("post_reset_fs", 0, 1'b1);
`ifdef NOISE_EN
        spot("post_reset_noise", 0, -1330);
`else
        spot("post_reset_s0", 0, 0);
`endif

        // Randomized traffic against the model
        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset(1 + $urandom_range(0, 2));
            end else begin
                if ($urandom_range(0, 3) == 0) dcv = 16'($urandom);
                else dcv = 16'($urandom_range(0, 8000) - 4000);
                drive($urandom_range(0, 9) < 7, 16'($urandom), 2'($urandom_range(0, 3)), dcv);
            end
        end
        idle(5);

        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d samples outstanding, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
